// File: rtl/bip_program_loader_pkg.sv
// Shared definitions for the BIP program loader:
//   - BIP opcode constants (5-bit opcode field of an instruction word)
//   - loader FSM state type
//   - clogb2: bits needed to hold a value (minimum 1)
package bip_program_loader_pkg;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return (bits == 0) ? 1 : bits;
  endfunction

endpackage

// File: rtl/bip_byte_timer.sv
// Inter-byte timeout counter for the program loader.
//   i_clk      clock
//   i_rst      synchronous reset, active-high
//   i_clear    force count to zero (has priority over i_enable)
//   i_enable   advance count by one
//   o_expired  count has reached TIMEOUT_CYC-1
module bip_byte_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned NB_CNT = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [NB_CNT-1:0] count_q;
  logic [NB_CNT-1:0] count_d;

  assign o_expired = (count_q == NB_CNT'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable && !o_expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bip_program_loader.sv
// BIP program loader: packs a UART byte stream (high byte first) into
// instruction words and writes them to instruction memory from address 0.
// The CPU is held in reset until a HALT word (opcode 0) has been written.
//   i_clk / i_rst        clock, synchronous active-high reset
//   i_rx_data/i_rx_valid received byte and its one-cycle strobe
//   i_reload             one-cycle strobe, restart loading at address 0
//   o_ins_wr_en/addr/data instruction memory write port
//   o_cpu_rst            CPU reset, high unless a program is loaded
//   o_done               program loaded, CPU released
//   o_error              memory filled without a HALT word
module bip_program_loader
  import bip_program_loader_pkg::*;
#(
  parameter  int unsigned NB_BITS       = 16,
  parameter  int unsigned INS_MEM_DEPTH = 2048,
  parameter  int unsigned NB_SIGX       = 11,
  parameter  int unsigned TIMEOUT_CYC   = 50000,
  localparam int unsigned NB_ADDR       = clogb2(INS_MEM_DEPTH - 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_reload,
  output logic               o_ins_wr_en,
  output logic [NB_ADDR-1:0] o_ins_wr_addr,
  output logic [NB_BITS-1:0] o_ins_wr_data,
  output logic               o_cpu_rst,
  output logic               o_done,
  output logic               o_error
);

  loader_state_e state_q, state_d;

  logic [7:0]                 hi_q, hi_d;
  logic [NB_ADDR-1:0]         wr_addr_q, wr_addr_d;
  logic [NB_BITS-1:0]         wr_data_q, wr_data_d;
  logic                       wr_en_q, wr_en_d;
  logic                       cpu_rst_q, cpu_rst_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [NB_BITS-NB_SIGX-1:0] opcode;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  assign opcode = wr_data_q[NB_BITS-1:NB_SIGX];

  // Timer sits at zero outside WAIT_LO, so it starts fresh with each high byte.
  assign timer_clear  = (state_q != ST_WAIT_LO);
  assign timer_enable = (state_q == ST_WAIT_LO) && !i_rx_valid && !i_reload;

  bip_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_byte_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (timer_clear),
    .i_enable  (timer_enable),
    .o_expired (timer_expired)
  );

  // State register (plus packer/address datapath)
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_WAIT_HI;
      hi_q      <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (i_reload) begin
      state_d   = ST_WAIT_HI;
      wr_addr_d = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_HI: begin
          if (i_rx_valid) begin
            hi_d    = i_rx_data;
            state_d = ST_WAIT_LO;
          end
        end
        ST_WAIT_LO: begin
          if (i_rx_valid) begin
            wr_data_d = NB_BITS'({hi_q, i_rx_data});
            state_d   = ST_WRITE;
          end else if (timer_expired) begin
            state_d = ST_WAIT_HI;
          end
        end
        ST_WRITE: begin
          if (opcode == OP_HALT) begin
            state_d = ST_DONE;
          end else if (wr_addr_q == NB_ADDR'(INS_MEM_DEPTH - 1)) begin
            state_d = ST_ERROR;
          end else begin
            wr_addr_d = wr_addr_q + 1'b1;
            state_d   = ST_WAIT_HI;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_WAIT_HI;
      endcase
    end
  end

  // Outputs are decoded from the next state so the flops line up with it.
  always_comb begin
    wr_en_d   = (state_d == ST_WRITE);
    cpu_rst_d = (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    error_d   = (state_d == ST_ERROR);
  end

  assign o_ins_wr_en   = wr_en_q;
  assign o_ins_wr_addr = wr_addr_q;
  assign o_ins_wr_data = wr_data_q;
  assign o_cpu_rst     = cpu_rst_q;
  assign o_done        = done_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_bip_program_loader.sv
module tb_bip_program_loader;

  localparam int unsigned B_DEPTH   = 4;
  localparam int unsigned B_TIMEOUT = 8;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       reload;
  logic       sel;

  logic        a_wr_en, a_cpu_rst, a_done, a_error;
  logic [10:0] a_wr_addr;
  logic [15:0] a_wr_data;
  logic        b_wr_en, b_cpu_rst, b_done, b_error;
  logic [1:0]  b_wr_addr;
  logic [15:0] b_wr_data;

  logic        obs_wr_en, obs_cpu_rst, obs_done, obs_error;
  logic [10:0] obs_addr;
  logic [15:0] obs_data;

  int checks;
  int errors;
  int a_wr_cnt;
  int b_wr_cnt;

  bip_program_loader dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid && !sel), .i_reload(reload && !sel),
    .o_ins_wr_en(a_wr_en), .o_ins_wr_addr(a_wr_addr), .o_ins_wr_data(a_wr_data),
    .o_cpu_rst(a_cpu_rst), .o_done(a_done), .o_error(a_error)
  );

  bip_program_loader #(
    .INS_MEM_DEPTH(B_DEPTH),
    .TIMEOUT_CYC  (B_TIMEOUT)
  ) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid && sel), .i_reload(reload && sel),
    .o_ins_wr_en(b_wr_en), .o_ins_wr_addr(b_wr_addr), .o_ins_wr_data(b_wr_data),
    .o_cpu_rst(b_cpu_rst), .o_done(b_done), .o_error(b_error)
  );

  always_comb begin
    if (sel) begin
      obs_wr_en = b_wr_en; obs_addr = {9'd0, b_wr_addr}; obs_data = b_wr_data;
      obs_cpu_rst = b_cpu_rst; obs_done = b_done; obs_error = b_error;
    end else begin
      obs_wr_en = a_wr_en; obs_addr = a_wr_addr; obs_data = a_wr_data;
      obs_cpu_rst = a_cpu_rst; obs_done = a_done; obs_error = a_error;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write pulses, counted one edge after they appear.
  always @(posedge clk) begin
    if (a_wr_en) a_wr_cnt++;
    if (b_wr_en) b_wr_cnt++;
  end

  function automatic int wr_cnt();
    return sel ? b_wr_cnt : a_wr_cnt;
  endfunction

  // One byte strobe, sample write port the cycle after, then one idle cycle.
  task automatic send_byte(input logic [7:0] b, output logic we,
                           output logic [10:0] addr, output logic [15:0] data);
    @(negedge clk); rx_data = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    we = obs_wr_en; addr = obs_addr; data = obs_data;
    @(negedge clk);
  endtask

  // High byte, then `gap` idle clocks, then the next byte strobe.
  task automatic send_gap(input logic [7:0] hi, input logic [7:0] lo, input int gap,
                          output logic we, output logic [10:0] addr, output logic [15:0] data);
    @(negedge clk); rx_data = hi; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data = lo; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    we = obs_wr_en; addr = obs_addr; data = obs_data;
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic pulse_reload();
    @(negedge clk); reload = 1'b1;
    @(negedge clk); reload = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0]; #1;
      checks++;
      if ({obs_wr_en, obs_addr, obs_data, obs_cpu_rst, obs_done, obs_error} !== {1'b0, 11'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_state dut%0d: we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b, want 0 000 0000 1 0 0",
                 s, obs_wr_en, obs_addr, obs_data, obs_cpu_rst, obs_done, obs_error);
      end
    end
    sel = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0]  bytes [6] = '{8'h18, 8'h05, 8'h28, 8'h03, 8'h00, 8'h00};
    logic [15:0] words [3] = '{16'h1805, 16'h2803, 16'h0000};
    logic we; logic [10:0] addr; logic [15:0] data;
    int c0;
    sel = 1'b0;
    c0 = wr_cnt();
    for (int i = 0; i < 3; i++) begin
      send_byte(bytes[2*i], we, addr, data);
      checks++;
      if (we !== 1'b0) begin errors++; $display("FAIL basic_hi_nowrite[%0d]: we=%b want 0", i, we); end
      send_byte(bytes[2*i+1], we, addr, data);
      checks++;
      if (we !== 1'b1 || addr !== 11'(i) || data !== words[i]) begin
        errors++;
        $display("FAIL basic_write[%0d]: we=%b addr=%h data=%h want 1 %h %h", i, we, addr, data, i, words[i]);
      end
      checks++;
      if (obs_wr_en !== 1'b0) begin errors++; $display("FAIL basic_pulse_len[%0d]: we=%b want 0", i, obs_wr_en); end
    end
    checks++;
    if (obs_done !== 1'b1 || obs_cpu_rst !== 1'b0 || obs_error !== 1'b0 || obs_addr !== 11'd2) begin
      errors++;
      $display("FAIL basic_done: done=%b cpu_rst=%b err=%b addr=%h want 1 0 0 002", obs_done, obs_cpu_rst, obs_error, obs_addr);
    end
    send_byte(8'h11, we, addr, data);
    send_byte(8'h22, we, addr, data);
    checks++;
    if (wr_cnt() - c0 !== 3 || obs_done !== 1'b1 || obs_addr !== 11'd2) begin
      errors++;
      $display("FAIL basic_ignore_in_done: writes=%0d done=%b addr=%h want 3 1 002", wr_cnt() - c0, obs_done, obs_addr);
    end
  endtask

  task automatic test_reload();
    logic we; logic [10:0] addr; logic [15:0] data;
    sel = 1'b0;
    pulse_reload();
    checks++;
    if (obs_cpu_rst !== 1'b1 || obs_done !== 1'b0 || obs_error !== 1'b0 || obs_addr !== 11'd0 || obs_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reload_state: cpu_rst=%b done=%b err=%b addr=%h we=%b want 1 0 0 000 0",
               obs_cpu_rst, obs_done, obs_error, obs_addr, obs_wr_en);
    end
    send_byte(8'h00, we, addr, data);
    send_byte(8'h07, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd0 || data !== 16'h0007) begin
      errors++;
      $display("FAIL reload_write: we=%b addr=%h data=%h want 1 000 0007", we, addr, data);
    end
    checks++;
    if (obs_done !== 1'b1 || obs_cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL reload_done: done=%b cpu_rst=%b want 1 0", obs_done, obs_cpu_rst);
    end
  endtask

  task automatic test_reload_coincident();
    logic we; logic [10:0] addr; logic [15:0] data;
    int c0;
    sel = 1'b0;
    pulse_reload();
    c0 = wr_cnt();
    send_byte(8'h12, we, addr, data);
    @(negedge clk); rx_data = 8'h34; rx_valid = 1'b1; reload = 1'b1;
    @(negedge clk); rx_valid = 1'b0; reload = 1'b0;
    checks++;
    if (obs_wr_en !== 1'b0 || obs_addr !== 11'd0) begin
      errors++;
      $display("FAIL coinc_no_write: we=%b addr=%h want 0 000", obs_wr_en, obs_addr);
    end
    @(negedge clk);
    checks++;
    if (wr_cnt() != c0) begin errors++; $display("FAIL coinc_count: writes=%0d want 0", wr_cnt() - c0); end
    // Stale high byte 0x12 must be gone: the next pair forms its own word.
    send_byte(8'h00, we, addr, data);
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL coinc_wait_hi: we=%b data=%h want 0", we, data); end
    send_byte(8'h05, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd0 || data !== 16'h0005) begin
      errors++;
      $display("FAIL coinc_write: we=%b addr=%h data=%h want 1 000 0005", we, addr, data);
    end
  endtask

  task automatic test_reset_midload();
    logic we; logic [10:0] addr; logic [15:0] data;
    sel = 1'b0;
    pulse_rst();
    send_byte(8'h18, we, addr, data);
    send_byte(8'h05, we, addr, data);
    send_byte(8'h28, we, addr, data);
    send_byte(8'h03, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd1 || data !== 16'h2803) begin
      errors++;
      $display("FAIL midrst_pre: we=%b addr=%h data=%h want 1 001 2803", we, addr, data);
    end
    send_byte(8'h11, we, addr, data);
    pulse_rst();
    checks++;
    if ({obs_wr_en, obs_addr, obs_data, obs_cpu_rst, obs_done, obs_error} !== {1'b0, 11'd0, 16'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_state: we=%b addr=%h data=%h cpu_rst=%b done=%b err=%b want 0 000 0000 1 0 0",
               obs_wr_en, obs_addr, obs_data, obs_cpu_rst, obs_done, obs_error);
    end
    send_byte(8'h00, we, addr, data);
    send_byte(8'h00, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd0 || data !== 16'h0000 || obs_done !== 1'b1) begin
      errors++;
      $display("FAIL midrst_reload: we=%b addr=%h data=%h done=%b want 1 000 0000 1", we, addr, data, obs_done);
    end
  endtask

  task automatic test_timeout();
    logic we; logic [10:0] addr; logic [15:0] data;
    sel = 1'b1;
    pulse_rst();
    // Low byte on the last permitted clock is still accepted.
    send_gap(8'h08, 8'h11, B_TIMEOUT - 1, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd0 || data !== 16'h0811) begin
      errors++;
      $display("FAIL timeout_edge_accept: we=%b addr=%h data=%h want 1 000 0811", we, addr, data);
    end
    // One clock later the orphan is dropped and the byte starts a new word.
    send_gap(8'h18, 8'h18, B_TIMEOUT, we, addr, data);
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL timeout_orphan: we=%b data=%h want 0", we, data); end
    send_byte(8'h07, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd1 || data !== 16'h1807) begin
      errors++;
      $display("FAIL timeout_next_word: we=%b addr=%h data=%h want 1 001 1807", we, addr, data);
    end
    send_byte(8'h00, we, addr, data);
    send_byte(8'h00, we, addr, data);
    checks++;
    if (we !== 1'b1 || addr !== 11'd2 || data !== 16'h0000 || obs_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_halt: we=%b addr=%h data=%h done=%b want 1 002 0000 1", we, addr, data, obs_done);
    end
  endtask

  task automatic test_mem_full();
    logic we; logic [10:0] addr; logic [15:0] data;
    int c0;
    sel = 1'b1;
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      send_byte(8'h08, we, addr, data);
      send_byte(8'(i + 1), we, addr, data);
      checks++;
      if (we !== 1'b1 || addr !== 11'(i) || data !== 16'(16'h0801 + i)) begin
        errors++;
        $display("FAIL full_write[%0d]: we=%b addr=%h data=%h want 1 %h %h", i, we, addr, data, i, 16'h0801 + i);
      end
    end
    checks++;
    if (obs_error !== 1'b1 || obs_cpu_rst !== 1'b1 || obs_done !== 1'b0 || obs_addr !== 11'd3) begin
      errors++;
      $display("FAIL full_error: err=%b cpu_rst=%b done=%b addr=%h want 1 1 0 003", obs_error, obs_cpu_rst, obs_done, obs_addr);
    end
    c0 = wr_cnt();
    send_byte(8'h00, we, addr, data);
    send_byte(8'h00, we, addr, data);
    checks++;
    if (wr_cnt() != c0 || obs_error !== 1'b1 || obs_done !== 1'b0) begin
      errors++;
      $display("FAIL full_ignore: writes=%0d err=%b done=%b want 0 1 0", wr_cnt() - c0, obs_error, obs_done);
    end
    pulse_reload();
    checks++;
    if (obs_error !== 1'b0 || obs_cpu_rst !== 1'b1 || obs_addr !== 11'd0) begin
      errors++;
      $display("FAIL full_reload: err=%b cpu_rst=%b addr=%h want 0 1 000", obs_error, obs_cpu_rst, obs_addr);
    end
  endtask

  initial begin
    checks = 0; errors = 0; a_wr_cnt = 0; b_wr_cnt = 0;
    sel = 1'b0; rst = 1'b1; rx_data = '0; rx_valid = 1'b0; reload = 1'b0;
    test_reset();
    test_basic();
    test_reload();
    test_reload_coincident();
    test_reset_midload();
    test_timeout();
    test_mem_full();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
